// File: rtl/multi_stretch.sv
// Multi-channel pulse stretcher: each channel synchronises an asynchronous input
// and holds its output asserted for at least MIN_DURATION_MS, then follows the input.
module multi_stretch #(
    parameter int unsigned          CHANNELS        = 4,
    parameter int unsigned          MIN_DURATION_MS = 200,
    parameter int unsigned          SYSTEM_CLOCK    = 50000000,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter bit                   RETRIGGER       = 1'b0,
    parameter logic [CHANNELS-1:0]  INVERT          = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic                any_active
);

    localparam longint unsigned MIN_PROD =
        (64'(MIN_DURATION_MS) * 64'(SYSTEM_CLOCK)) / 64'd1000;
    localparam longint unsigned MIN_CLKS = (MIN_PROD == 64'd0) ? 64'd1 : MIN_PROD;
    localparam int unsigned     CNT_W    = $clog2(MIN_CLKS + 64'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_CLKS - 64'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FOLLOW = 2'd2
    } state_t;

    logic [CHANNELS-1:0] sync_ff [SYNC_STAGES];
    logic [CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] lout_d;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];

    // Synchroniser operates on logical polarity and ignores en, so a held input
    // never looks like a fresh edge when the channel is re-enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_ff[s] <= '0;
            end
            sync_q <= '0;
        end else begin
            sync_ff[0] <= in ^ INVERT;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
            sync_q <= sync;
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];
    assign rise = sync & ~sync_q;

    // Per-channel state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state and next logical output; a retrigger wins over the terminal count.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            lout_d[i]  = 1'b0;
            if (!en[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (rise[i]) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = '0;
                        end
                    end
                    HOLD: begin
                        if (RETRIGGER && rise[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = sync[i] ? FOLLOW : IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    FOLLOW: begin
                        if (!sync[i]) begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            case (state_d[i])
                HOLD:    lout_d[i] = 1'b1;
                FOLLOW:  lout_d[i] = sync[i];
                default: lout_d[i] = 1'b0;
            endcase
        end
    end

    // Outputs registered from next-state values so any_active aligns with out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out        <= INVERT;
            any_active <= 1'b0;
        end else begin
            out        <= lout_d ^ INVERT;
            any_active <= |lout_d;
        end
    end

endmodule

// File: tb/tb_multi_stretch.sv
// Scoreboard bench for multi_stretch: stimulus queues expected output edges,
// a negedge monitor pops and compares every observed edge and reset snapshot.
module tb_multi_stretch;

    localparam int NS      = 5;
    localparam int TIMEOUT = 3000;

    typedef struct {
        logic lvl;
        int   cyc;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [1:0] out_a;
        logic       any_a;
        logic [1:0] out_b;
        logic       any_b;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] en;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic [1:0] out_a;
    logic [1:0] out_b;
    logic       any_a;
    logic       any_b;
    logic [NS-1:0] lv;
    logic [NS-1:0] lv_prev;

    int    cyc = 0;
    int    n_cmp;
    int    n_err;
    bit    done = 1'b0;
    ev_t   exp_q [NS][$];
    snap_t snap_q [$];
    string nm [NS] = '{"a_out0", "a_out1", "a_any", "b_out0", "b_any"};

    multi_stretch #(
        .CHANNELS(2), .MIN_DURATION_MS(10), .SYSTEM_CLOCK(1000),
        .SYNC_STAGES(2), .RETRIGGER(1'b0), .INVERT(2'b10)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_a),
        .out(out_a), .any_active(any_a)
    );

    multi_stretch #(
        .CHANNELS(2), .MIN_DURATION_MS(10), .SYSTEM_CLOCK(1000),
        .SYNC_STAGES(2), .RETRIGGER(1'b1), .INVERT(2'b00)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_b),
        .out(out_b), .any_active(any_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign lv = {any_b, out_b[0], any_a, out_a[1], out_a[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev(input int s, input logic lvl, input int c);
        ev_t e;
        e.lvl = lvl;
        e.cyc = c;
        exp_q[s].push_back(e);
    endtask

    task automatic push_snap(input int c, input logic [1:0] oa, input logic aa,
                             input logic [1:0] ob, input logic ab);
        snap_t s;
        s.cyc = c; s.out_a = oa; s.any_a = aa; s.out_b = ob; s.any_b = ab;
        snap_q.push_back(s);
    endtask

    task automatic wait_to(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    // Monitor: compares snapshots and every output edge against the queues.
    initial begin
        snap_t s;
        ev_t   e;
        n_cmp   = 0;
        n_err   = 0;
        lv_prev = '0;
        forever begin
            @(negedge clk);
            if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
                s = snap_q.pop_front();
                chk("snap a_out", 32'(out_a), 32'(s.out_a));
                chk("snap a_any", 32'(any_a), 32'(s.any_a));
                chk("snap b_out", 32'(out_b), 32'(s.out_b));
                chk("snap b_any", 32'(any_b), 32'(s.any_b));
            end
            if (cyc == 2) begin
                lv_prev = lv;
            end else if (cyc > 2) begin
                for (int k = 0; k < NS; k++) begin
                    if (lv[k] !== lv_prev[k]) begin
                        if (exp_q[k].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL %s unexpected edge: got level %0b expected no edge (cycle %0d)",
                                     nm[k], lv[k], cyc);
                        end else begin
                            e = exp_q[k].pop_front();
                            chk({nm[k], " level"}, 32'(lv[k]), 32'(e.lvl));
                            chk({nm[k], " cycle"}, 32'(cyc), 32'(e.cyc));
                        end
                    end
                end
                lv_prev = lv;
            end
            if (done || cyc > TIMEOUT) begin
                if (!done) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL timeout: got cycle %0d expected done by %0d", cyc, TIMEOUT);
                end
                for (int k = 0; k < NS; k++) begin
                    chk({nm[k], " pending"}, 32'(exp_q[k].size()), 32'd0);
                end
                chk("snap pending", 32'(snap_q.size()), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    // Stimulus: directed vectors, expected edges computed by hand (MIN_CLKS = 10).
    initial begin
        int t;
        rst_n = 1'b0;
        en    = 2'b11;
        in_a  = 2'b10;
        in_b  = 2'b00;
        push_snap(2, 2'b10, 1'b0, 2'b00, 1'b0);
        wait_to(3);
        rst_n = 1'b1;
        wait_to(10);

        // Single-cycle pulse: high 10 cycles, 3 edges after sampling.
        t = cyc + 1;
        in_a[0] = 1'b1;
        ev(0, 1'b1, t + 2); ev(0, 1'b0, t + 12);
        ev(2, 1'b1, t + 2); ev(2, 1'b0, t + 12);
        wait_to(t);
        in_a[0] = 1'b0;
        wait_to(t + 30);

        // 25-cycle input: output follows with equal latency.
        t = cyc + 1;
        in_a[0] = 1'b1;
        ev(0, 1'b1, t + 2); ev(0, 1'b0, t + 27);
        ev(2, 1'b1, t + 2); ev(2, 1'b0, t + 27);
        wait_to(t + 24);
        in_a[0] = 1'b0;
        wait_to(t + 45);

        // Two pulses 6 cycles apart: retrigger stretches to 16, otherwise 10.
        t = cyc + 1;
        in_a[0] = 1'b1; in_b[0] = 1'b1;
        ev(0, 1'b1, t + 2); ev(0, 1'b0, t + 12);
        ev(2, 1'b1, t + 2); ev(2, 1'b0, t + 12);
        ev(3, 1'b1, t + 2); ev(3, 1'b0, t + 18);
        ev(4, 1'b1, t + 2); ev(4, 1'b0, t + 18);
        wait_to(t);
        in_a[0] = 1'b0; in_b[0] = 1'b0;
        wait_to(t + 5);
        in_a[0] = 1'b1; in_b[0] = 1'b1;
        wait_to(t + 6);
        in_a[0] = 1'b0; in_b[0] = 1'b0;
        wait_to(t + 35);

        // Active-low channel 1: single low pulse gives 10 cycles low.
        t = cyc + 1;
        in_a[1] = 1'b0;
        ev(1, 1'b0, t + 2); ev(1, 1'b1, t + 12);
        ev(2, 1'b1, t + 2); ev(2, 1'b0, t + 12);
        wait_to(t);
        in_a[1] = 1'b1;
        wait_to(t + 30);

        // Disable at HOLD count 4, re-enable with input still high: no new pulse.
        t = cyc + 1;
        in_a[0] = 1'b1;
        ev(0, 1'b1, t + 2); ev(0, 1'b0, t + 7);
        ev(2, 1'b1, t + 2); ev(2, 1'b0, t + 7);
        wait_to(t + 6);
        en[0] = 1'b0;
        wait_to(t + 12);
        en[0] = 1'b1;
        wait_to(t + 30);
        in_a[0] = 1'b0;
        wait_to(t + 40);

        // Reset pulse mid-FOLLOW with input held high: abort, then fresh HOLD.
        t = cyc + 1;
        in_a[0] = 1'b1;
        ev(0, 1'b1, t + 2);  ev(0, 1'b0, t + 21);
        ev(0, 1'b1, t + 24); ev(0, 1'b0, t + 43);
        ev(2, 1'b1, t + 2);  ev(2, 1'b0, t + 21);
        ev(2, 1'b1, t + 24); ev(2, 1'b0, t + 43);
        wait_to(t + 20);
        rst_n = 1'b0;
        push_snap(t + 21, 2'b10, 1'b0, 2'b00, 1'b0);
        wait_to(t + 21);
        rst_n = 1'b1;
        wait_to(t + 40);
        in_a[0] = 1'b0;
        wait_to(t + 60);
        done = 1'b1;
    end

endmodule

// File: doc/multi_stretch.md
MULTI_STRETCH -- requirements
Module: multi_stretch

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent stretch channels (1..32).
REQ-002 SHALL have parameter MIN_DURATION_MS, default 200, minimum asserted output width in ms.
REQ-003 SHALL have parameter SYSTEM_CLOCK, default 50000000, clk frequency in Hz.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-005 SHALL have parameter RETRIGGER, default 0; 1 = rising edge during HOLD restarts the minimum-width count.
REQ-006 SHALL have parameter INVERT, default 0 ([CHANNELS-1:0]); bit i set = channel i active-low on both in and out.
REQ-007 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-009 SHALL have port en  input  CHANNELS  per-channel enable, active high.
REQ-010 SHALL have port in  input  CHANNELS  asynchronous pulse inputs.
REQ-011 SHALL have port out  output  CHANNELS  stretched outputs, registered.
REQ-012 SHALL have port any_active  output  1  registered OR of all logically active channels.

Function
REQ-013 SHALL compute MIN_CLKS = (MIN_DURATION_MS*SYSTEM_CLOCK)/1000, forced to 1 if the result is 0; counter width $clog2(MIN_CLKS+1), 64-bit intermediate product.
REQ-014 SHALL pass each in[i] XOR INVERT[i] through SYNC_STAGES flops; sync = last stage, sync_q = sync delayed one cycle; rise = sync & ~sync_q.
REQ-015 SHALL run per channel a state machine IDLE / HOLD / FOLLOW; logical out = 0 in IDLE, 1 in HOLD, sync in FOLLOW; out[i] = logical out XOR INVERT[i].
REQ-016 IDLE: on rise -> HOLD, count cleared to 0, logical out 1 at that same edge.
REQ-017 HOLD: count increments each cycle; at count == MIN_CLKS-1 -> FOLLOW if sync = 1, else -> IDLE; short pulse yields logical out high exactly MIN_CLKS cycles.
REQ-018 HOLD with RETRIGGER = 1: rise clears count to 0 and stays in HOLD; rise takes priority over the count-terminal transition in the same cycle.
REQ-019 HOLD with RETRIGGER = 0: rise ignored.
REQ-020 FOLLOW: logical out tracks sync registered; sync = 0 -> IDLE; subsequent rise from IDLE starts a new HOLD.
REQ-021 Latency: input assertion to out assertion = SYNC_STAGES+1 rising edges (edge capturing in into stage 0 counts as the first); same latency for deassertion in FOLLOW.
REQ-022 en[i] = 0: channel forced to IDLE, count 0, logical out 0 at next edge; overrides simultaneous rise; synchroniser keeps running so no false rise on re-enable while input held high.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels have no interaction.
REQ-024 any_active SHALL be registered from next-state logical outs, asserting on the same edge as the first asserting out.

Reset
REQ-025 rst_n = 0 at a rising edge: all synchroniser flops and sync_q to logical 0, all states IDLE, counts 0, out = INVERT, any_active = 0.
REQ-026 Reset mid-HOLD or mid-FOLLOW SHALL abort the pulse at that edge with no residual count.
REQ-027 Input held logically high across reset release SHALL produce a rise and one full HOLD period after release.

Verification (CHANNELS=2, SYSTEM_CLOCK=1000, MIN_DURATION_MS=10 -> MIN_CLKS=10, SYNC_STAGES=2)
REQ-028 1-cycle pulse on in[0] -> out[0] high exactly 10 cycles, starting 3 edges after in sampled high; any_active identical.
REQ-029 in[0] high 25 cycles -> out[0] high 25 cycles, equal rise/fall latency 3.
REQ-030 RETRIGGER=1, pulses at cycles 0 and 6 -> out[0] high 16 cycles; RETRIGGER=0 same stimulus -> 10 cycles.
REQ-031 INVERT=2'b10, in[1] idles high, pulses low 1 cycle -> out[1] low 10 cycles, idles high; out[0] unaffected.
REQ-032 en[0] dropped at HOLD count 4 -> out[0] low next edge; en[0] reasserted with in[0] held high -> no new pulse.
REQ-033 rst_n low for 1 cycle mid-FOLLOW with in[0] held high -> out[0] low at reset edge, then a fresh HOLD; out[0] reasserts on the 3rd edge after release and then follows in[0].
